// File: rtl/opsum_gather_bus_if.sv
// Handshake bundle for opsum_gather_bus: per-PE psum offers on one side, one tagged
// output stream on the other. master = the gather bus, slave = PEs plus downstream sink.
interface opsum_gather_bus_if #(
  parameter int PE_NUMS    = 14,
  parameter int ID_LEN     = 4,
  parameter int PSUM_WIDTH = 32
);
  logic [PE_NUMS-1:0]            pe_valid;
  logic [PE_NUMS*PSUM_WIDTH-1:0] pe_opsum;
  logic [PE_NUMS-1:0]            pe_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [ID_LEN+PSUM_WIDTH-1:0]  out_tag_value;

  modport master (
    input  pe_valid, pe_opsum, out_ready,
    output pe_ready, out_valid, out_tag_value
  );

  modport slave (
    output pe_valid, pe_opsum, out_ready,
    input  pe_ready, out_valid, out_tag_value
  );
endinterface

// File: rtl/opsum_gather_bus.sv
// Collects PE partial sums onto one {id, psum} stream with round-robin arbitration.
// Define OPSUM_GATHER_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module opsum_gather_bus #(
  parameter int PE_NUMS    = 14,
  parameter int ID_LEN     = 4,
  parameter int PSUM_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              set_id,
  input  logic [ID_LEN-1:0] id_scan_in,
  output logic [ID_LEN-1:0] id_scan_out,
  opsum_gather_bus_if.master bus
);
  localparam int IDX_W = (PE_NUMS > 1) ? $clog2(PE_NUMS) : 1;

  logic [ID_LEN-1:0]     id_reg  [PE_NUMS];
  logic [ID_LEN-1:0]     id_next [PE_NUMS];
  logic [IDX_W-1:0]      ptr_reg;
  logic [IDX_W-1:0]      ptr_next;
  logic                  out_valid_reg;
  logic [ID_LEN+PSUM_WIDTH-1:0] out_tag_value_reg;

  logic [IDX_W-1:0]      cand_idx;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_found;
  logic                  slot_free;
  logic                  grant;
  logic [PSUM_WIDTH-1:0] win_opsum;

  // ID scan chain: id[0] takes the serial input, every other stage takes its neighbour.
  generate
    for (genvar gi = 0; gi < PE_NUMS; gi++) begin : g_scan
      if (gi == 0) begin : g_head
        assign id_next[gi] = id_scan_in;
      end else begin : g_body
        assign id_next[gi] = id_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PE_NUMS; i++) id_reg[i] <= '0;
    end else if (set_id) begin
      for (int i = 0; i < PE_NUMS; i++) id_reg[i] <= id_next[i];
    end
  end

  assign id_scan_out = id_reg[PE_NUMS-1];

  // Walk offsets from the highest down so the smallest offset from the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = PE_NUMS - 1; i >= 0; i--) begin
      if (int'(ptr_reg) + i >= PE_NUMS)
        cand_idx = IDX_W'(int'(ptr_reg) + i - PE_NUMS);
      else
        cand_idx = IDX_W'(int'(ptr_reg) + i);
      if (bus.pe_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign slot_free = !out_valid_reg || bus.out_ready;
  assign grant     = rst && enable && !set_id && slot_free && win_found;
  assign win_opsum = bus.pe_opsum[win_idx*PSUM_WIDTH +: PSUM_WIDTH];

`ifdef OPSUM_GATHER_FIXED_PRIO_EN
  assign ptr_next = '0;
`else
  assign ptr_next = (win_idx == IDX_W'(PE_NUMS - 1)) ? '0 : win_idx + 1'b1;
`endif

  generate
    for (genvar gi = 0; gi < PE_NUMS; gi++) begin : g_ready
      assign bus.pe_ready[gi] = grant && (win_idx == IDX_W'(gi));
    end
  endgenerate

  // A grant may coincide with the downstream accepting the previous word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg     <= 1'b0;
      out_tag_value_reg <= '0;
      ptr_reg           <= '0;
    end else if (grant) begin
      out_valid_reg     <= 1'b1;
      out_tag_value_reg <= {id_reg[win_idx], win_opsum};
      ptr_reg           <= ptr_next;
    end else if (bus.out_ready) begin
      out_valid_reg     <= 1'b0;
    end
  end

  assign bus.out_valid     = out_valid_reg;
  assign bus.out_tag_value = out_tag_value_reg;
endmodule

// File: tb/tb_opsum_gather_bus.sv
// Directed bench for opsum_gather_bus: per-cycle reference model plus hand-computed literals.
module tb_opsum_gather_bus;
  localparam int N  = 14;
  localparam int IW = 4;
  localparam int PW = 32;
`ifdef OPSUM_GATHER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          set_id;
  logic [IW-1:0] id_scan_in;
  logic [IW-1:0] id_scan_out;

  opsum_gather_bus_if #(.PE_NUMS(N), .ID_LEN(IW), .PSUM_WIDTH(PW)) bus ();

  opsum_gather_bus #(.PE_NUMS(N), .ID_LEN(IW), .PSUM_WIDTH(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .set_id      (set_id),
    .id_scan_in  (id_scan_in),
    .id_scan_out (id_scan_out),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: state as seen after the most recent rising edge.
  int              m_id [N];
  int              m_ptr;
  bit              m_valid;
  logic [IW+PW-1:0] m_word;

  always @(negedge clk) begin : model
    int w;
    int k;
    logic [N-1:0] exp_ready;
    if (rst !== 1'b1) begin
      for (int i = 0; i < N; i++) m_id[i] = 0;
      m_ptr   = 0;
      m_valid = 1'b0;
      m_word  = '0;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_tag", 64'(bus.out_tag_value), 64'd0);
      check("rst_pe_ready", 64'(bus.pe_ready), 64'd0);
      check("rst_scan_out", 64'(id_scan_out), 64'd0);
    end else begin
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) check("out_tag", 64'(bus.out_tag_value), 64'(m_word));
      check("scan_out", 64'(id_scan_out), 64'(m_id[N-1]));
      w = -1;
      if (enable && !set_id && (!m_valid || bus.out_ready)) begin
        for (int off = 0; off < N; off++) begin
          k = (m_ptr + off) % N;
          if (w < 0 && bus.pe_valid[k]) w = k;
        end
      end
      exp_ready = (w >= 0) ? (N'(1) << w) : '0;
      check("pe_ready", 64'(bus.pe_ready), 64'(exp_ready));
      if (m_valid && bus.out_ready)
        $display("xfer id=%0d psum=%h", m_word[IW+PW-1:PW], m_word[PW-1:0]);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_word  = {IW'(m_id[w]), bus.pe_opsum[w*PW +: PW]};
        if (!FIXED) m_ptr = (w + 1) % N;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
      if (set_id) begin
        for (int i = N - 1; i > 0; i--) m_id[i] = m_id[i-1];
        m_id[0] = int'(id_scan_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; set_id = 1'b0; id_scan_in = '0;
    bus.pe_valid = '0; bus.pe_opsum = '0; bus.out_ready = 1'b0;

    mid();
    check("lit_rst_scan_out", 64'(id_scan_out), 64'd0);
    check("lit_rst_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst = 1'b1;

    // Scan 6..0 twice so id[k] = k mod 7
    for (int i = 0; i < N; i++) begin
      set_id = 1'b1;
      id_scan_in = IW'(6 - (i % 7));
      tick();
    end
    set_id = 1'b0;
    check("lit_scan_out_14", 64'(id_scan_out), 64'd6);

    // Single PE
    enable = 1'b1; bus.out_ready = 1'b1;
    bus.pe_valid = 14'h0008;
    bus.pe_opsum[3*PW +: PW] = 32'h0000_00AB;
    mid();
    check("lit_single_ready", 64'(bus.pe_ready), 64'h0008);
    tick();
    bus.pe_valid = '0;
    check("lit_single_valid", 64'(bus.out_valid), 64'd1);
    check("lit_single_tag", 64'(bus.out_tag_value), 64'h3_0000_00AB);
    tick();

    // Grant PE13 alone so the pointer wraps to 0
    bus.pe_valid = 14'h2000;
    tick();
    bus.pe_valid = '0;
    tick();

    // Round robin, all PEs valid, PE k offers psum k
    for (int k = 0; k < N; k++) bus.pe_opsum[k*PW +: PW] = PW'(k);
    bus.pe_valid = 14'h3FFF;
    for (int c = 0; c < 16; c++) begin
      mid();
      check("lit_rr_grant", 64'(bus.pe_ready), FIXED ? 64'd1 : (64'd1 << (c % N)));
      if (c > 0) check("lit_rr_stream", 64'(bus.out_valid), 64'd1);
      tick();
    end

    // Backpressure: last grant was PE1 (id 1) in round-robin, PE0 (id 0) in fixed
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mid();
      check("lit_bp_ready", 64'(bus.pe_ready), 64'd0);
      check("lit_bp_valid", 64'(bus.out_valid), 64'd1);
      check("lit_bp_hold", 64'(bus.out_tag_value), FIXED ? 64'h0 : 64'h1_0000_0001);
      tick();
    end
    bus.out_ready = 1'b1;
    mid();
    check("lit_bp_release", 64'(bus.pe_ready), FIXED ? 64'h0001 : 64'h0004);
    tick();
    bus.pe_valid = '0;
    tick();
    tick();

    // Gating by set_id with a pending word
    bus.out_ready = 1'b0;
    bus.pe_valid = 14'h3FFF;
    tick();
    set_id = 1'b1; id_scan_in = 4'd9; bus.out_ready = 1'b1;
    mid();
    check("lit_gate_setid", 64'(bus.pe_ready), 64'd0);
    tick();
    check("lit_gate_setid_drain", 64'(bus.out_valid), 64'd0);
    set_id = 1'b0;

    // Gating by enable with a pending word
    bus.out_ready = 1'b0;
    tick();
    enable = 1'b0;
    mid();
    check("lit_gate_en", 64'(bus.pe_ready), 64'd0);
    check("lit_gate_en_hold", 64'(bus.out_valid), 64'd1);
    tick();
    bus.out_ready = 1'b1;
    mid();
    check("lit_gate_en_ready", 64'(bus.pe_ready), 64'd0);
    tick();
    check("lit_gate_en_drain", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-burst
    enable = 1'b1;
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("lit_async_valid", 64'(bus.out_valid), 64'd0);
    check("lit_async_ready", 64'(bus.pe_ready), 64'd0);
    tick();
    rst = 1'b1;
    mid();
    check("lit_post_rst_grant", 64'(bus.pe_ready), 64'h0001);
    tick();
    bus.pe_valid = '0;
    enable = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/opsum_gather_bus.md
Name: opsum_gather_bus

Overview:
- Return-direction companion of the ifmap multicast X bus: collects output partial sums from a row of PE_NUMS PE wrappers and serializes them onto one tagged stream toward the global buffer.
- Each PE holds a scan-loaded ID; each word leaves as {ID, psum} so the buffer can place it.
- Round-robin arbitration across PEs; one registered output stage with a valid/ready handshake.

Parameters:
- PE_NUMS, 14, number of PEs on the bus.
- ID_LEN, 4, width of each PE tag ID.
- PSUM_WIDTH, 32, partial-sum width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  when 0, no new grants; the output stage still drains.
- set_id  input  1  ID scan-shift enable.
- id_scan_in  input  ID_LEN  scan chain serial input.
- id_scan_out  output  ID_LEN  scan chain serial output, equal to id[PE_NUMS-1].
- pe_valid  input  PE_NUMS  per-PE opsum valid (PE opsum enable).
- pe_opsum  input  PE_NUMS*PSUM_WIDTH  flattened opsums; PE k occupies bits [k*PSUM_WIDTH +: PSUM_WIDTH].
- pe_ready  output  PE_NUMS  per-PE accept, one-hot or zero.
- out_valid  output  1  out_tag_value holds a word.
- out_ready  input  1  downstream accept.
- out_tag_value  output  ID_LEN+PSUM_WIDTH  {id of source PE, psum}.

Behaviour:
- Reset (rst=0, asynchronous):
  - all id[k]=0; id_scan_out=0.
  - out_valid=0; out_tag_value=0.
  - round-robin pointer=0; pe_ready=0.
- ID scan: on each cycle with set_id=1, id[0]<=id_scan_in and id[k]<=id[k-1]. After PE_NUMS shifts, the first value shifted in sits in id[PE_NUMS-1].
- Grant condition: slot_free = !out_valid || out_ready. A grant occurs only when enable=1, set_id=0, slot_free=1 and at least one pe_valid bit is set.
- Round-robin arbitration: search starts at pointer p and wraps modulo PE_NUMS. The first k with pe_valid[k]=1 wins.
- pe_ready[k] is combinational and asserted only for the winner. The transfer happens in the same cycle (pe_valid[k] & pe_ready[k]).
- On transfer:
  - out_tag_value<={id[k], opsum_k} and out_valid<=1 at the next edge; latency is 1 cycle from accept to out_valid.
  - p<=(k+1) mod PE_NUMS.
- Without a grant: out_valid<=0 if out_ready=1, otherwise hold. out_tag_value holds stable while out_valid=1 and out_ready=0.
- Throughput is 1 word/cycle when out_ready stays high. A back-to-back accept and a new grant in the same cycle are allowed.
- Multiple PEs may share an ID; the tag reports the ID, not the PE index.
- set_id=1 blocks all grants; a pending output word still drains.
- enable falling mid-burst: no new grants; the held word completes normally.
- Reset mid-transfer: pending word dropped, out_valid=0 immediately (asynchronous).
- pe_valid withdrawn without a grant: legal, nothing recorded.

Optional Feature:
- Macro: OPSUM_GATHER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index pe_valid wins; the pointer is unused and stays 0.
- Undefined: round-robin as described above.

Test Plan:
- Reset and scan: rst low then high; shift 6,5,4,3,2,1,0,6,5,4,3,2,1,0 with set_id=1 -> id[13..7]=6..0, id[6..0]=6..0; id_scan_out=6 after the 14th shift; id_scan_out=0 and out_valid=0 during reset.
- Single PE: pe_valid[3]=1, psum 0x0000_00AB, out_ready=1 -> pe_ready=0x0008 in the same cycle; next cycle out_valid=1, out_tag_value={id[3]=3, 0x000000AB}.
- Round robin: all 14 pe_valid=1 (PE k psum=k), out_ready=1 -> grants in order 0,1,...,13, one per cycle; out_valid continuous for 14 cycles; wraps to PE0 if still valid. With OPSUM_GATHER_FIXED_PRIO_EN, PE0 is granted every cycle.
- Backpressure: out_ready=0 with a word held -> pe_ready=0; out_tag_value stable for 5 cycles; raise out_ready -> held word leaves and a new grant occurs in that cycle.
- Gating: set_id=1 or enable=0 with pe_valid=0x3FFF -> pe_ready=0; a pending word still accepted by out_ready.
- Async reset mid-burst: drop rst between edges with out_valid=1 -> out_valid=0 immediately; after release the first grant goes to PE0.
